// File: rtl/fact_pkg.sv
// Shared types for the factorial engine.
// Holds the FSM state encoding used by fact_engine.
package fact_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fact_mul_step.sv
// One combinational multiply step of the factorial loop.
// Ports: acc (WIDTH), cnt (N_WIDTH) in; product (low WIDTH bits)
// and ovf_step (upper N_WIDTH bits of full product nonzero) out.
module fact_mul_step #(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 8
) (
    input  logic [WIDTH-1:0]   acc,
    input  logic [N_WIDTH-1:0] cnt,
    output logic [WIDTH-1:0]   product,
    output logic               ovf_step
);

    localparam int FW = WIDTH + N_WIDTH;

    logic [FW-1:0] a_ext;
    logic [FW-1:0] c_ext;
    logic [FW-1:0] full;

    // Widen both operands first so the product is never truncated.
    assign a_ext = {{N_WIDTH{1'b0}}, acc};
    assign c_ext = {{WIDTH{1'b0}}, cnt};
    assign full  = a_ext * c_ext;

    assign product  = full[WIDTH-1:0];
    assign ovf_step = |full[FW-1:WIDTH];

endmodule

// File: rtl/fact_engine.sv
// Iterative n! engine with start/result handshakes.
// Ports: clk1, reset (sync, active-high); start, n, start_ready;
// result, overflow, result_valid, result_ready.
module fact_engine
    import fact_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int N_WIDTH  = 8,
    parameter int SATURATE = 0
) (
    input  logic               clk1,
    input  logic               reset,
    input  logic               start,
    input  logic [N_WIDTH-1:0] n,
    output logic               start_ready,
    output logic [WIDTH-1:0]   result,
    output logic               overflow,
    output logic               result_valid,
    input  logic               result_ready
);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   acc_nx;
    logic [N_WIDTH-1:0] cnt;
    logic [N_WIDTH-1:0] cnt_nx;
    logic               ovf;
    logic               ovf_nx;

    logic [WIDTH-1:0]   product;
    logic               ovf_step;

    fact_mul_step #(
        .WIDTH   (WIDTH),
        .N_WIDTH (N_WIDTH)
    ) u_step (
        .acc      (acc),
        .cnt      (cnt),
        .product  (product),
        .ovf_step (ovf_step)
    );

    always_ff @(posedge clk1) begin
        if (reset) begin
            state <= S_IDLE;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            cnt   <= cnt_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        cnt_nx       = cnt;
        ovf_nx       = ovf;
        start_ready  = 1'b0;
        result_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                if (start) begin
                    acc_nx   = WIDTH'(1);
                    cnt_nx   = n;
                    ovf_nx   = 1'b0;
                    state_nx = S_MULT;
                end
            end
            S_MULT: begin
                // cnt of 0 or 1 contributes nothing.
                if (cnt <= N_WIDTH'(1)) begin
                    state_nx = S_DONE;
                end else if (SATURATE != 0 && ovf_step) begin
                    acc_nx   = '1;
                    ovf_nx   = 1'b1;
                    state_nx = S_DONE;
                end else begin
                    acc_nx = product;
                    cnt_nx = cnt - N_WIDTH'(1);
                    ovf_nx = ovf | ovf_step;
                end
            end
            S_DONE: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign result   = result_valid ? acc : '0;
    assign overflow = result_valid & ovf;

endmodule

// File: doc/fact_engine.md
FACT_ENGINE -- requirements
Module: fact_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 32: result/accumulator width in bits.
REQ-002 SHALL have parameter N_WIDTH, default 8: operand width in bits.
REQ-003 SHALL have parameter SATURATE, default 0: 0 = wrap modulo 2^WIDTH; 1 = saturate to all-ones and terminate early.
REQ-004 SHALL have port clk1  in  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port start  in  1: request; accepted on an edge where start=1 and start_ready=1.
REQ-007 SHALL have port n  in  N_WIDTH: operand; sampled only on acceptance.
REQ-008 SHALL have port start_ready  out  1: high only in IDLE.
REQ-009 SHALL have port result  out  WIDTH: n! (wrapped or saturated); valid while result_valid=1.
REQ-010 SHALL have port overflow  out  1: true n! exceeds 2^WIDTH-1; valid while result_valid=1.
REQ-011 SHALL have port result_valid  out  1: result available; held until consumed.
REQ-012 SHALL have port result_ready  in  1: consumer acknowledge; result consumed on an edge where result_valid=1 and result_ready=1.

Function
REQ-013 SHALL implement FSM states IDLE, MULT, DONE.
REQ-014 SHALL, on acceptance in IDLE, load acc=1, cnt=n, ovf=0 and go to MULT.
REQ-015 SHALL, in MULT with cnt>=2: acc<=low WIDTH bits of acc*cnt; cnt<=cnt-1; ovf<=ovf OR (upper N_WIDTH bits of the WIDTH+N_WIDTH product nonzero).
REQ-016 SHALL, in MULT with cnt<=1, go to DONE with no multiply.
REQ-017 SHALL, when SATURATE=1 and a multiply overflows, set acc=all-ones, ovf=1 and go to DONE on that same edge.
REQ-018 SHALL make result_valid rise max(n,1) cycles after the acceptance edge when no early termination occurs; n=0 and n=1 both yield result=1, overflow=0.
REQ-019 SHALL, in DONE, hold result, overflow and result_valid stable until consumed, then go to IDLE.
REQ-020 SHALL ignore start outside IDLE; a start arriving in the same cycle as consumption in DONE is not accepted (start_ready=0) and must be re-presented.
REQ-021 SHALL drive result and overflow to 0 whenever result_valid=0.
REQ-022 SHALL compute the multiply at full WIDTH+N_WIDTH width with no truncation before the overflow check.

Reset
REQ-023 SHALL, when reset=1 at an edge, go to IDLE from any state and clear acc, cnt and ovf, discarding any in-flight or unconsumed result.
REQ-024 SHALL drive after reset: start_ready=1, result_valid=0, result=0, overflow=0.
REQ-025 SHALL give reset priority over start and result_ready on the same edge.

Structure
REQ-026 SHALL place the FSM state type and state encodings in shared package fact_pkg.
REQ-027 SHALL place the combinational multiply step in sub-module fact_mul_step: inputs acc and cnt; outputs product (WIDTH bits) and ovf_step.
REQ-028 SHALL keep all registered state in fact_engine; fact_mul_step SHALL contain no registers.

Verification
REQ-029 SHALL cover: WIDTH=32, n=7 -> result=5040, overflow=0, result_valid 7 cycles after acceptance.
REQ-030 SHALL cover: n=0, then n=1 -> result=1, overflow=0, result_valid 1 cycle after acceptance in each case.
REQ-031 SHALL cover: WIDTH=32, SATURATE=0, n=13 -> result=1932053504 (13! mod 2^32), overflow=1, result_valid 13 cycles after acceptance.
REQ-032 SHALL cover: WIDTH=32, SATURATE=1, n=20 -> result=0xFFFFFFFF, overflow=1, result_valid 8 cycles after acceptance (overflow on the ×13 step).
REQ-033 SHALL cover: n=5 with result_ready held low 5 cycles and start pulsed meanwhile -> result=120 stable throughout, start ignored; result_ready=1 -> IDLE next cycle.
REQ-034 SHALL cover: reset asserted 3 cycles into n=9 -> IDLE next cycle, result_valid=0; a new n=4 then yields result=24.
